// File: rtl/store_align_unit.sv
// store_align_unit
//
// Store-side narrowing and byte-lane placement between the EX/MEM store
// request and the data-memory write port. Legal stores are narrowed to
// byte/half/word, replicated across the 32-bit write bus with matching byte
// enables, and buffered in a DEPTH-entry FIFO. Misaligned or illegal stores
// are consumed and dropped with an error pulse. Values that do not fit the
// narrowed width raise an informational overflow pulse.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready. req_ready depends only on internal state, never on
// mem_ready, so a full unit cannot accept on the cycle it pops.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     store request handshake
//   req_addr            byte address of the store
//   req_data            register value to store
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   mem_valid/ready     memory write handshake
//   mem_addr            word-aligned write address (bits [1:0] = 0)
//   mem_wdata           lane-replicated write data
//   mem_be              byte enables (0 while mem_valid = 0)
//   align_err           one-cycle pulse: store dropped as misaligned/illegal
//   err_addr            address of the last dropped store
//   trunc_ovf           one-cycle pulse: value not representable in width
//   pending             FIFO occupancy

module store_align_unit #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [31:0]              req_data,
    input  logic [1:0]               req_size,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     align_err,
    output logic [ADDR_W-1:0]        err_addr,
    output logic                     trunc_ovf,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage: one narrowed store per entry
    logic [ADDR_W-1:0] ent_addr  [DEPTH];
    logic [31:0]       ent_wdata [DEPTH];
    logic [3:0]        ent_be    [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // Registered copy of the head entry; drives the memory port directly so
    // that mem_addr/mem_wdata keep their last value once the FIFO drains.
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_wdata;
    logic [3:0]        head_be;

    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] n_addr;
    logic [31:0]       n_wdata;
    logic [3:0]        n_be;
    logic              n_ovf;
    logic [PTR_W-1:0]  rd_next;
    logic [CNT_W-1:0]  count_next;

    assign req_ready = (count < CNT_W'(DEPTH));
    assign mem_valid = (count != '0);
    assign pending   = count;
    assign mem_addr  = head_addr;
    assign mem_wdata = head_wdata;
    assign mem_be    = mem_valid ? head_be : 4'b0000;

    assign accept = req_valid && req_ready;
    assign pop    = mem_valid && mem_ready;
    assign push   = accept && legal;

    // Alignment legality and narrowing of the incoming request
    always_comb begin
        legal   = 1'b0;
        n_wdata = req_data;
        n_be    = 4'b0000;
        n_ovf   = 1'b0;
        n_addr  = {req_addr[ADDR_W-1:2], 2'b00};
        case (req_size)
            2'b00: begin
                legal   = 1'b1;
                n_wdata = {4{req_data[7:0]}};
                n_be    = 4'b0001 << req_addr[1:0];
                // representable only if the upper bits are a pure sign extension
                n_ovf   = !((&req_data[31:7]) || !(|req_data[31:7]));
            end
            2'b01: begin
                legal   = !req_addr[0];
                n_wdata = {2{req_data[15:0]}};
                n_be    = 4'b0011 << req_addr[1:0];
                n_ovf   = !((&req_data[31:15]) || !(|req_data[31:15]));
            end
            2'b10: begin
                legal   = (req_addr[1:0] == 2'b00);
                n_wdata = req_data;
                n_be    = 4'b1111;
                n_ovf   = 1'b0;
            end
            default: begin
                legal   = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_next    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Entry storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr]  <= n_addr;
            ent_wdata[wr_ptr] <= n_wdata;
            ent_be[wr_ptr]    <= n_be;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_addr  <= '0;
            head_wdata <= '0;
            head_be    <= '0;
            align_err  <= 1'b0;
            err_addr   <= '0;
            trunc_ovf  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;

            // Next head is either an already buffered entry or, when the
            // queue is (or becomes) otherwise empty, the store being pushed.
            if (count_next != '0) begin
                if (push && (rd_next == wr_ptr)) begin
                    head_addr  <= n_addr;
                    head_wdata <= n_wdata;
                    head_be    <= n_be;
                end else begin
                    head_addr  <= ent_addr[rd_next];
                    head_wdata <= ent_wdata[rd_next];
                    head_be    <= ent_be[rd_next];
                end
            end

            align_err <= accept && !legal;
            if (accept && !legal) begin
                err_addr <= req_addr;
            end
            trunc_ovf <= push && n_ovf;
        end
    end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Store-side counterpart of load-path sign extension: narrows a 32-bit register value to byte/half/word and places it on the correct memory byte lanes.
- Sits between the EX/MEM stage store request and the data-memory write port.
- Buffers up to DEPTH stores behind a valid/ready handshake.
- Flags misaligned or illegal stores, and values that do not fit the narrowed width.

Parameters:
DEPTH, 2, store FIFO entries; power of two, >=2
ADDR_W, 32, byte address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  store request valid
req_ready  out  1  unit can accept a request
req_addr  in  ADDR_W  byte address
req_data  in  32  register value to store
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
mem_valid  out  1  write to memory pending
mem_ready  in  1  memory accepts write
mem_addr  out  ADDR_W  word-aligned address, bits [1:0] always 0
mem_wdata  out  32  lane-replicated data
mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
align_err  out  1  one-cycle pulse: misaligned/illegal store dropped
err_addr  out  ADDR_W  address of last dropped store
trunc_ovf  out  1  one-cycle pulse: value not representable in stored width
pending  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge):
  - Outputs cleared: pending=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, align_err=0, trunc_ovf=0, err_addr=0.
  - Buffered stores are discarded.
  - Reset mid-transfer drops the entry even if mem_ready is high that cycle.
- Handshakes:
  - req_ready = (pending < DEPTH), combinational from state only.
  - Request accepted when req_valid && req_ready.
  - Memory write completes when mem_valid && mem_ready.
  - No same-cycle pass-through: when full, req_ready stays 0 even if a pop occurs that cycle.
- Alignment check:
  - Legal: byte at any address; half with addr[0]=0; word with addr[1:0]=0.
  - Every accepted request that is not legal (including size 11) is consumed but not enqueued.
  - align_err=1 on the cycle after acceptance; err_addr is loaded with req_addr on the same edge.
- Narrowing, computed at accept and stored in the FIFO entry:
  - byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, be=4'b0011<<addr[1:0].
  - word: wdata=d, be=4'b1111.
  - mem_addr={addr[ADDR_W-1:2],2'b00}.
- trunc_ovf:
  - Asserted on the cycle after acceptance of a legal store.
  - byte: asserted unless d[31:7] is all-0 or all-1. half: same test on d[31:15]. word: never.
  - Informational only; the store is still enqueued.
- Queue ordering and output stability:
  - FIFO order strictly preserved.
  - mem_valid = (pending != 0).
  - Head entry (mem_addr/mem_wdata/mem_be) held stable while mem_valid && !mem_ready.
  - When mem_valid=0, mem_be=0; mem_addr/mem_wdata hold their last value.
- Latency: a store accepted at edge N is visible with mem_valid=1 after edge N (earliest handshake at edge N+1).
- Occupancy:
  - Simultaneous push and pop leaves pending unchanged and keeps both entries in order.
  - An errored request with a simultaneous pop decrements pending.
  - Read/write pointers wrap modulo DEPTH.
  - pending never exceeds DEPTH or underflows. mem_ready while empty has no effect.

Test Plan:
- Reset then sb addr=0x1003 data=0xFFFFFF80, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0x80808080, mem_be=1000, trunc_ovf=0; pending returns to 0 after the handshake.
- sh addr=0x2002 data=0x00012345 -> mem_wdata=0x23452345, mem_be=1100, trunc_ovf pulses for one cycle.
- sw addr=0x3002, then sh addr=0x3001, then size 11 -> each consumed; align_err pulses three times; err_addr ends at the third request's address; pending stays 0; mem_valid never rises.
- mem_ready=0, push DEPTH words 0xA,0xB -> req_ready=0, pending=2. Raise mem_ready -> 0xA then 0xB in order. Outputs are stable while stalled, and req_ready stays 0 on the pop cycle.
- Continuous back-to-back sw stream with mem_ready toggling every cycle -> no loss or duplication; order matches; pending within 0..2; pointers wrap correctly.
- pending=2 with mem_valid=1, mem_ready=1; assert rst_n=0 for one edge -> pending=0, mem_valid=0, mem_be=0; no write handshake counted that cycle.
